// File: rtl/in_val_collector.sv
// rtl/in_val_collector.sv - nibble-stream receiver that reassembles frames into a word; optional IN_VAL_COLLECTOR_PARITY_EN adds in_par odd-parity checking.
module in_val_collector #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [3:0]             in_nib,
    input  logic                   in_vld,
    input  logic                   in_first,
`ifdef IN_VAL_COLLECTOR_PARITY_EN
    input  logic                   in_par,
`endif
    input  logic                   out_rdy,
    output logic [4*NIBBLES-1:0]   out_val,
    output logic                   out_vld,
    output logic                   busy,
    output logic                   err
);

    localparam int WIDTH = 4 * NIBBLES;
    localparam int CW    = $clog2(NIBBLES + 1);
    localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, FULL = 2'd2} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic [WIDTH-1:0] out_val_q, out_val_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] ins;
    logic [WIDTH-1:0] first_word;
    logic             par_bad;

`ifdef IN_VAL_COLLECTOR_PARITY_EN
    assign par_bad = in_vld & ~(^{in_par, in_nib});
`else
    assign par_bad = 1'b0;
`endif

    // A restarted frame starts from a clean shadow so stale low slots never leak.
    assign first_word = {in_nib, {(WIDTH-4){1'b0}}};

    always_comb begin
        ins = shadow_q;
        for (int k = 0; k < NIBBLES; k++) begin
            if (cnt_q == CW'(k)) begin
                ins[WIDTH-1-4*k -: 4] = in_nib;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            shadow_q  <= '0;
            out_val_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shadow_q  <= shadow_d;
            out_val_q <= out_val_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shadow_d  = shadow_q;
        out_val_d = out_val_q;
        err_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_vld) begin
                    if (par_bad) begin
                        shadow_d = '0;
                        err_d    = 1'b1;
                    end else if (in_first) begin
                        shadow_d = first_word;
                        cnt_d    = CW'(1);
                        state_d  = FILL;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            FILL: begin
                if (in_vld) begin
                    if (par_bad) begin
                        shadow_d = '0;
                        cnt_d    = '0;
                        err_d    = 1'b1;
                        state_d  = IDLE;
                    end else if (in_first) begin
                        shadow_d = first_word;
                        cnt_d    = CW'(1);
                        err_d    = 1'b1;
                    end else if (cnt_q == LAST) begin
                        shadow_d  = ins;
                        out_val_d = ins;
                        cnt_d     = '0;
                        state_d   = FULL;
                    end else begin
                        shadow_d = ins;
                        cnt_d    = cnt_q + CW'(1);
                    end
                end
            end
            FULL: begin
                if (out_rdy) begin
                    state_d = IDLE;
                    if (in_vld) begin
                        if (in_first && !par_bad) begin
                            shadow_d = first_word;
                            cnt_d    = CW'(1);
                            state_d  = FILL;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end else if (in_vld) begin
                    err_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        out_val = out_val_q;
        out_vld = (state_q == FULL);
        busy    = (state_q == FILL);
        err     = err_q;
    end

endmodule

// File: tb/tb_in_val_collector.sv
// tb/tb_in_val_collector.sv - scoreboard bench for in_val_collector with directed frames.
module tb_in_val_collector;

    logic        clk;
    logic        rst;
    logic [3:0]  in_nib;
    logic        in_vld;
    logic        in_first;
`ifdef IN_VAL_COLLECTOR_PARITY_EN
    logic        in_par;
`endif
    logic        out_rdy;
    logic [15:0] out_val;
    logic        out_vld;
    logic        busy;
    logic        err;

    int total = 0;
    int bad   = 0;
    int err_cnt  = 0;
    int busy_cnt = 0;
    int vld_cnt  = 0;
    logic [15:0] sb[$];

    in_val_collector #(.NIBBLES(4)) dut (
        .clk(clk),
        .rst(rst),
        .in_nib(in_nib),
        .in_vld(in_vld),
        .in_first(in_first),
`ifdef IN_VAL_COLLECTOR_PARITY_EN
        .in_par(in_par),
`endif
        .out_rdy(out_rdy),
        .out_val(out_val),
        .out_vld(out_vld),
        .busy(busy),
        .err(err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: a transfer is committed on the next rising edge when both are high.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (err === 1'b1) err_cnt++;
            if (busy === 1'b1) busy_cnt++;
            if (out_vld === 1'b1) vld_cnt++;
            if (out_vld === 1'b1 && out_rdy === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("unexpected_word", {16'h0, out_val}, 32'hdead_beef);
                end else begin
                    chk("word", {16'h0, out_val}, {16'h0, sb.pop_front()});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic nib(input logic [3:0] n, input logic f, input logic badpar);
        in_nib   = n;
        in_vld   = 1'b1;
        in_first = f;
`ifdef IN_VAL_COLLECTOR_PARITY_EN
        in_par   = (~^n) ^ badpar;
`endif
        tick();
        in_vld   = 1'b0;
        in_first = 1'b0;
    endtask

    task automatic frame(input logic [15:0] w);
        nib(w[15:12], 1'b1, 1'b0);
        nib(w[11:8],  1'b0, 1'b0);
        nib(w[7:4],   1'b0, 1'b0);
        nib(w[3:0],   1'b0, 1'b0);
    endtask

    int e0, b0, v0;

    initial begin
        rst = 1'b1; in_nib = '0; in_vld = 1'b0; in_first = 1'b0; out_rdy = 1'b0;
`ifdef IN_VAL_COLLECTOR_PARITY_EN
        in_par = 1'b0;
`endif
        #2 rst = 1'b0;
        #2;
        chk("rst_out_val", {16'h0, out_val}, 32'h0);
        chk("rst_out_vld", {31'h0, out_vld}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_err", {31'h0, err}, 32'h0);
        tick();
        rst = 1'b1;
        tick();

        // Frame in with consumer always ready
        out_rdy = 1'b1;
        e0 = err_cnt; b0 = busy_cnt; v0 = vld_cnt;
        sb.push_back(16'hABCD);
        frame(16'hABCD);
        chk("frame_vld", {31'h0, out_vld}, 32'h1);
        chk("frame_val", {16'h0, out_val}, 32'hABCD);
        tick();
        chk("frame_vld_drop", {31'h0, out_vld}, 32'h0);
        tick();
        chk("frame_busy_cycles", busy_cnt - b0, 3);
        chk("frame_vld_cycles", vld_cnt - v0, 1);
        chk("frame_no_err", err_cnt - e0, 0);

        // Back-pressure and overrun
        out_rdy = 1'b0;
        sb.push_back(16'h1234);
        frame(16'h1234);
        nib(4'h5, 1'b1, 1'b0);
        chk("ovr_err", {31'h0, err}, 32'h1);
        chk("ovr_val_held", {16'h0, out_val}, 32'h1234);
        chk("ovr_vld_held", {31'h0, out_vld}, 32'h1);
        out_rdy = 1'b1;
        tick();
        chk("ovr_vld_drop", {31'h0, out_vld}, 32'h0);
        chk("ovr_err_pulse", {31'h0, err}, 32'h0);

        // Resync on a premature first marker
        sb.push_back(16'h9123);
        nib(4'h7, 1'b1, 1'b0);
        nib(4'h8, 1'b0, 1'b0);
        nib(4'h9, 1'b1, 1'b0);
        chk("resync_err", {31'h0, err}, 32'h1);
        chk("resync_busy", {31'h0, busy}, 32'h1);
        nib(4'h1, 1'b0, 1'b0);
        nib(4'h2, 1'b0, 1'b0);
        nib(4'h3, 1'b0, 1'b0);
        chk("resync_val", {16'h0, out_val}, 32'h9123);
        tick();

        // Stray nibble in IDLE
        nib(4'hF, 1'b0, 1'b0);
        chk("stray_err", {31'h0, err}, 32'h1);
        chk("stray_busy", {31'h0, busy}, 32'h0);
        chk("stray_vld", {31'h0, out_vld}, 32'h0);
        tick();

        // Back-to-back: second first nibble lands in the handshake cycle
        e0 = err_cnt;
        sb.push_back(16'h0001);
        sb.push_back(16'hFFFF);
        frame(16'h0001);
        frame(16'hFFFF);
        chk("b2b_val", {16'h0, out_val}, 32'hFFFF);
        tick();
        tick();
        chk("b2b_no_err", err_cnt - e0, 0);

        // Asynchronous reset mid-frame
        out_rdy = 1'b0;
        e0 = err_cnt;
        nib(4'hC, 1'b1, 1'b0);
        nib(4'hA, 1'b0, 1'b0);
        chk("mid_busy", {31'h0, busy}, 32'h1);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_busy", {31'h0, busy}, 32'h0);
        chk("mid_rst_val", {16'h0, out_val}, 32'h0);
        chk("mid_rst_vld", {31'h0, out_vld}, 32'h0);
        chk("mid_rst_err", {31'h0, err}, 32'h0);
        tick();
        rst = 1'b1;
        out_rdy = 1'b1;
        sb.push_back(16'hBEEF);
        frame(16'hBEEF);
        chk("beef_val", {16'h0, out_val}, 32'hBEEF);
        tick();
        chk("mid_no_err", err_cnt - e0, 0);

`ifdef IN_VAL_COLLECTOR_PARITY_EN
        // Parity error aborts the frame
        nib(4'h2, 1'b1, 1'b0);
        nib(4'h4, 1'b0, 1'b0);
        nib(4'h6, 1'b0, 1'b1);
        chk("par_err", {31'h0, err}, 32'h1);
        chk("par_busy", {31'h0, busy}, 32'h0);
        nib(4'h8, 1'b0, 1'b0);
        chk("par_vld", {31'h0, out_vld}, 32'h0);
        tick();
        sb.push_back(16'h1357);
        frame(16'h1357);
        chk("par_next_val", {16'h0, out_val}, 32'h1357);
        tick();
`endif

        tick();
        chk("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
